minterm_scan_ctrl: RTL

Sequencer that exhaustively exercises a 3-input combinational function block (decoder-based sum-of-minterms circuits of the F(x,y,z) = Σm(...) family). On a start request it walks x,y,z through all 8 combinations, samples the function output, and builds the observed truth table. It also compares each sample against a reference built from a programmable minterm mask through an internal 3-to-8 decoder, then reports pass/fail with a done pulse. It sits between a host/testbench controller and any function block under test.

---
 rtl/minterm_scan_ctrl_pkg.sv | 18 +
 rtl/minterm_scan_ctrl_if.sv | 28 ++
 rtl/Decoder_3X8.sv | 14 +
 rtl/minterm_scan_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/minterm_scan_ctrl_pkg.sv
// Purpose: shared types and constants for the minterm scan sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package minterm_scan_ctrl_pkg;

    localparam int NUM_MINTERMS = 8;
    localparam int IDX_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [IDX_W-1:0]        idx_t;
    typedef logic [NUM_MINTERMS-1:0] tt_t;

endpackage

// File: rtl/minterm_scan_ctrl_if.sv
// Purpose: host/DUT-facing bundle of the scan sequencer (request, mask, probe drive, results).
// Latency: none (wires only).
// Backpressure: start is simply ignored while busy; there is no queuing.
// Ports: start/mask/f_in flow host->ctrl; xyz/busy/done/truth/err_cnt/pass flow ctrl->host.
interface minterm_scan_ctrl_if;
    import minterm_scan_ctrl_pkg::*;

    logic       start;
    tt_t        mask;
    logic       f_in;
    idx_t       xyz;
    logic       busy;
    logic       done;
    tt_t        truth;
    logic [3:0] err_cnt;
    logic       pass;

    modport master (
        output start, mask, f_in,
        input  xyz, busy, done, truth, err_cnt, pass
    );

    modport slave (
        input  start, mask, f_in,
        output xyz, busy, done, truth, err_cnt, pass
    );

endinterface

// File: rtl/Decoder_3X8.sv
// Purpose: 3-to-8 one-hot decoder, D[{x,y,z}] = 1 (x is the MSB).
// Latency: combinational.
// Backpressure: none.
// Ports: x, y, z select inputs; D one-hot output.
module Decoder_3X8 (
    input  logic       x,
    input  logic       y,
    input  logic       z,
    output logic [7:0] D
);

    assign D = 8'b0000_0001 << {x, y, z};

endmodule

// File: rtl/minterm_scan_ctrl.sv
// Purpose: walks xyz through 0..7, samples f_in into a truth table, counts mismatches vs a minterm mask.
// Latency: done pulses 8*SETTLE cycles after start is accepted; busy drops one cycle later.
// Backpressure: start is accepted only in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst_n (async active-low); bus = slave side of minterm_scan_ctrl_if.
module minterm_scan_ctrl
    import minterm_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input logic                clk,
    input logic                rst_n,
    minterm_scan_ctrl_if.slave bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam idx_t       IDX_LAST    = idx_t'(NUM_MINTERMS - 1);

    state_t     state_q,   state_d;
    idx_t       idx_q,     idx_d;
    logic [3:0] cnt_q,     cnt_d;
    tt_t        mask_q,    mask_d;
    tt_t        truth_q,   truth_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic       pass_q,    pass_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;

    tt_t  dec;
    logic ref_bit;
    logic sample_now;
    logic last_sample;

    // Reference value for the current minterm: the decoder selects mask bit idx.
    Decoder_3X8 u_dec (
        .x (idx_q[2]),
        .y (idx_q[1]),
        .z (idx_q[0]),
        .D (dec)
    );

    assign ref_bit     = |(dec & mask_q);
    assign sample_now  = (state_q == ST_DRIVE) && (cnt_q == SETTLE_LAST);
    assign last_sample = sample_now && (idx_q == IDX_LAST);

    // State and all counters/results share one register block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            truth_q   <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            truth_q   <= truth_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start)   state_d = ST_DRIVE;
            ST_DRIVE: if (last_sample) state_d = ST_DONE;
            ST_DONE:                   state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        truth_d   = truth_q;
        err_cnt_d = err_cnt_q;
        pass_d    = pass_q;
        // busy/done are registered images of the upcoming state, so they line up with xyz.
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_d    = bus.mask;
                    truth_d   = '0;
                    err_cnt_d = '0;
                    pass_d    = 1'b0;
                    idx_d     = '0;
                    cnt_d     = '0;
                end
            end
            ST_DRIVE: begin
                if (sample_now) begin
                    truth_d[idx_q] = bus.f_in;
                    err_cnt_d      = err_cnt_q + {3'b000, bus.f_in ^ ref_bit};
                    cnt_d          = '0;
                    if (last_sample) begin
                        // idx doubles as the xyz drive, so returning it to 0 parks the block at input 0.
                        idx_d  = '0;
                        pass_d = (err_cnt_d == 4'd0);
                    end else begin
                        idx_d = idx_q + idx_t'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.xyz     = idx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.truth   = truth_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.pass    = pass_q;

endmodule
